// File: rtl/mul_chain_result_collector.sv
// Receive side of the six-lane bf16 multiplier chain: gathers per-lane results
// into one word per completed set and queues the words for a valid/ready consumer.
module mul_chain_result_collector #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [6*DW-1:0]        outputs,
    input  logic [5:0]             final_output_stbs,
    output logic [6*DW-1:0]        res_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic [5:0]             lanes_pending,
    output logic                   dup_err,
    output logic                   ovf_err
);

    localparam int unsigned LANES = 6;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned WW    = LANES * DW;

    // Lanes that must report before a set is complete, per chain mode.
    function automatic logic [LANES-1:0] mode_mask(input logic [1:0] m);
        logic [LANES-1:0] mask;
        mask = 6'b111111;
        case (m)
            2'b11:   mask = 6'b111111;
            2'b10:   mask = 6'b001111;
            2'b01:   mask = 6'b000011;
            default: mask = 6'b000001;
        endcase
        return mask;
    endfunction

    logic [1:0]       mode_q;
    logic [LANES-1:0] cap;
    logic [DW-1:0]    lane_q [LANES];
    logic [WW-1:0]    mem    [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;

    logic [LANES-1:0] req_c;
    logic [LANES-1:0] hit_c;
    logic [LANES-1:0] new_c;
    logic [LANES-1:0] dup_c;
    logic             complete_c;
    logic [WW-1:0]    word_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;

    // Capture / completion decode; an empty set follows the live mode.
    always_comb begin
        req_c      = (cap == '0) ? mode_mask(mode) : mode_mask(mode_q);
        hit_c      = final_output_stbs & req_c;
        new_c      = hit_c & ~cap;
        dup_c      = hit_c & cap;
        complete_c = ((cap | hit_c) == req_c);
        word_c     = '0;
        for (int k = 0; k < LANES; k++) begin
            if (req_c[k]) begin
                word_c[k*DW +: DW] = new_c[k] ? outputs[k*DW +: DW] : lane_q[k];
            end
        end
    end

    // FIFO handshake decode; a pop frees room for a push at full.
    always_comb begin
        pop_c  = res_valid & res_ready;
        push_c = complete_c & ((occ < CW'(DEPTH)) | pop_c);
        drop_c = complete_c & ~push_c;
    end

    // Set assembly state and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= 2'b11;
            cap     <= '0;
            dup_err <= 1'b0;
            ovf_err <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            if (cap == '0) begin
                mode_q <= mode;
            end
            for (int k = 0; k < LANES; k++) begin
                if (new_c[k]) begin
                    lane_q[k] <= outputs[k*DW +: DW];
                end
            end
            cap <= complete_c ? '0 : (cap | new_c);
            if (dup_c != '0) begin
                dup_err <= 1'b1;
            end
            if (drop_c) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Result FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= word_c;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign res_valid     = (occ != '0);
    assign res_data      = mem[rd_ptr];
    assign count         = occ;
    assign lanes_pending = req_c & ~cap;

endmodule

// File: tb/tb_mul_chain_result_collector.sv
// Scoreboard bench for mul_chain_result_collector: a set-level reference model
// predicts delivered words, occupancy and flags; a monitor checks every pop.
module tb_mul_chain_result_collector;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [95:0]   outputs;
    logic [5:0]    final_output_stbs;
    logic [95:0]   res_data;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] count;
    logic [5:0]    lanes_pending;
    logic          dup_err;
    logic          ovf_err;

    always #5 clk = ~clk;

    mul_chain_result_collector #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mode(mode), .outputs(outputs),
        .final_output_stbs(final_output_stbs), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready), .count(count),
        .lanes_pending(lanes_pending), .dup_err(dup_err), .ovf_err(ovf_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the current set as "which lanes hold a value", plus a word queue.
    logic [95:0] exp_q[$];
    bit          m_have [6];
    logic [15:0] m_val  [6];
    logic [1:0]  m_mode_q;
    int          m_occ;
    bit          m_dup;
    bit          m_ovf;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [5:0] lanes_for(input logic [1:0] m);
        case (m)
            2'b11:   return 6'b111111;
            2'b10:   return 6'b001111;
            2'b01:   return 6'b000011;
            default: return 6'b000001;
        endcase
    endfunction

    function automatic bit set_empty();
        for (int k = 0; k < 6; k++) if (m_have[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [5:0] model_req(input logic [1:0] live);
        return set_empty() ? lanes_for(live) : lanes_for(m_mode_q);
    endfunction

    function automatic logic [5:0] model_pending(input logic [1:0] live);
        logic [5:0] r;
        r = model_req(live);
        for (int k = 0; k < 6; k++) if (m_have[k]) r[k] = 1'b0;
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            m_have[k] = 1'b0;
            m_val[k]  = '0;
        end
        m_mode_q = 2'b11;
        m_occ    = 0;
        m_dup    = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_step(input logic [1:0] m, input logic [5:0] s,
                              input logic [95:0] d, input logic r);
        logic [5:0]  req;
        logic [95:0] word;
        bit          done;
        bit          was_empty;
        bit          pop;
        req       = model_req(m);
        was_empty = set_empty();
        done      = 1'b1;
        word      = '0;
        for (int k = 0; k < 6; k++) begin
            if (req[k]) begin
                if (m_have[k]) begin
                    word[k*16 +: 16] = m_val[k];
                    if (s[k]) m_dup = 1'b1;
                end else if (s[k]) begin
                    word[k*16 +: 16] = d[k*16 +: 16];
                end else begin
                    done = 1'b0;
                end
            end
        end
        pop = (m_occ > 0) && r;
        if (done) begin
            if (m_occ < DEPTH || pop) begin
                exp_q.push_back(word);
                m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
            for (int k = 0; k < 6; k++) m_have[k] = 1'b0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (req[k] && s[k] && !m_have[k]) begin
                    m_have[k] = 1'b1;
                    m_val[k]  = d[k*16 +: 16];
                end
            end
        end
        if (was_empty) m_mode_q = m;
        if (pop) m_occ--;
    endtask

    // One clock: drive, check model-visible outputs mid-cycle, then step the model.
    task automatic cycle(input logic [1:0] m, input logic [5:0] s,
                         input logic [95:0] d, input logic r);
        mode = m; final_output_stbs = s; outputs = d; res_ready = r;
        @(negedge clk);
        check("lanes_pending", 96'(lanes_pending), 96'(model_pending(m)));
        check("count", 96'(count), 96'(m_occ));
        check("res_valid", 96'(res_valid), 96'(m_occ != 0));
        check("dup_err", 96'(dup_err), 96'(m_dup));
        check("ovf_err", 96'(ovf_err), 96'(m_ovf));
        model_step(m, s, d, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; res_ready = 1'b0; final_output_stbs = '0; mode = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        check("rst_valid", 96'(res_valid), 96'(0));
        check("rst_data", res_data, 96'(0));
        check("rst_count", 96'(count), 96'(0));
        check("rst_dup", 96'(dup_err), 96'(0));
        check("rst_ovf", 96'(ovf_err), 96'(0));
        check("rst_pending", 96'(lanes_pending), 96'(6'b111111));
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) cycle(mode, '0, '0, 1'b1);
        check("drain_done", 96'(exp_q.size()), 96'(0));
    endtask

    // Monitor: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_spurious: got %h, expected no word", res_data);
            end else begin
                check("pop_word", res_data, exp_q.pop_front());
            end
        end
    end

    logic [95:0] w1;
    logic [95:0] rd;
    logic [1:0]  rm;

    initial begin
        rst = 1'b0; mode = 2'b11; outputs = '0; final_output_stbs = '0; res_ready = 1'b0;
        model_clear();
        do_reset();

        // All six lanes in one cycle.
        w1 = {16'hC000, 16'h4040, 16'h3F00, 16'hBFC0, 16'h4000, 16'h3F80};
        cycle(2'b11, 6'b111111, w1, 1'b1);
        check("t1_data", res_data, w1);
        check("t1_count", 96'(count), 96'(1));
        cycle(2'b11, '0, '0, 1'b1);
        check("t1_count_after", 96'(count), 96'(0));

        // Split arrival: lanes 0-2, then 3-5 three cycles later.
        cycle(2'b11, 6'b000111, {$urandom, $urandom, $urandom}, 1'b1);
        check("t2_pending", 96'(lanes_pending), 96'(6'b111000));
        cycle(2'b00, '0, '0, 1'b1);
        cycle(2'b01, '0, '0, 1'b1);
        cycle(2'b11, 6'b111000, {$urandom, $urandom, $urandom}, 1'b1);
        check("t2_valid", 96'(res_valid), 96'(1));
        cycle(2'b11, '0, '0, 1'b1);

        // Mode 01 with all strobes: only lanes 0-1 delivered, no duplicate.
        cycle(2'b01, 6'b111111, {$urandom, $urandom, $urandom}, 1'b0);
        check("t3_upper_zero", 96'(res_data[95:32]), 96'(0));
        check("t3_dup", 96'(dup_err), 96'(0));
        drain();

        // Duplicate strobe on lane 0 keeps the first value.
        cycle(2'b11, 6'b000001, 96'h3F80, 1'b0);
        cycle(2'b11, 6'b000001, 96'h4000, 1'b0);
        cycle(2'b11, 6'b111110, {$urandom, $urandom, $urandom}, 1'b0);
        check("t4_dup", 96'(dup_err), 96'(1));
        check("t4_lane0", 96'(res_data[15:0]), 96'(16'h3F80));
        drain();

        // Overflow: five sets with the consumer stalled.
        for (int i = 0; i < 5; i++) cycle(2'b11, 6'b111111, {$urandom, $urandom, $urandom}, 1'b0);
        check("t5_count", 96'(count), 96'(DEPTH));
        check("t5_ovf", 96'(ovf_err), 96'(1));
        drain();
        check("t5_valid_low", 96'(res_valid), 96'(0));

        // Reset mid-set with a queued word, then a clean set.
        cycle(2'b11, 6'b111111, {$urandom, $urandom, $urandom}, 1'b0);
        cycle(2'b11, 6'b010101, {$urandom, $urandom, $urandom}, 1'b0);
        do_reset();
        rd = {$urandom, $urandom, $urandom};
        cycle(2'b11, 6'b111111, rd, 1'b0);
        check("t6_word", res_data, rd);
        drain();

        // Randomized traffic.
        rm = 2'b11;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rm = 2'($urandom_range(0, 3));
            cycle(rm, 6'($urandom & $urandom), {$urandom, $urandom, $urandom},
                  1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
